ex_wb_stage: RTL and testbench
==============================

# ex_wb_stage

EX/WB pipeline register plus write-back stage and the 8×8-bit register file of the 8-bit pipelined core. It captures the EX-stage results (adder sum, sign-extended immediate, destination register, control bits) on each clock and selects the write-back value. It commits that value to the register file and serves the ID stage's two combinational read ports. It also drives the `ex_wb_rd` and `forward_data` signals that the EX forwarding unit compares against.

## Interface
Parameters:
- none (data width fixed at 8, register address fixed at 3).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the EX/WB latch and suppress commit this cycle.
- `flush`  in  1  replace the latch contents with a bubble; overrides `stall`.
- `signaltoReg_in`  in  1  write-back source select: 0 = `sum_in`, 1 = `extensor_in`.
- `writeReg_in`  in  1  instruction writes a register.
- `rd_in`  in  3  destination register.
- `sum_in`  in  8  EX adder result.
- `extensor_in`  in  8  EX sign-extended immediate.
- `rs1_addr`, `rs2_addr`  in  3 each  ID read addresses.
- `rs1_data`, `rs2_data`  out  8 each  combinational read data.
- `ex_wb_rd`  out  3  destination of the pending write, or 0 if none.
- `forward_data`  out  8  pending write-back value, or 0 if none.
- `wb_count`  out  8  count of committed register writes, wraps modulo 256.

## Operation
- **Latch fields:** `l_wen`, `l_sel`, `l_rd`, `l_sum`, `l_ext`.
- **Latch update priority, per rising edge:**
  - `reset`: all fields cleared.
  - `flush`: `l_wen` = 0; the other fields are don't-care but are cleared.
  - `stall`: all fields held.
  - Otherwise: load from the `_in` ports.
- **Write-back value:** `wb_data = l_sel ? l_ext : l_sum`.
- **Pending write:** `pend = l_wen && (l_rd != 0)`.
- **Commit:** on a rising edge with `!reset && !stall && pend`, `regs[l_rd] <= wb_data` and `wb_count` increments by 1. Commit uses the pre-edge latch contents.
  - A `flush` in the same cycle does not cancel this commit. Flush only affects the value being loaded.
- **Register x0:** always reads 0. Writes to x0 are discarded and not counted.
- **Read ports (combinational):**
  - Address 0 returns 0.
  - Otherwise, if `pend && !stall && addr == l_rd`, return `wb_data` (write-through bypass).
  - Otherwise return `regs[addr]`.
- **Forwarding outputs:**
  - `ex_wb_rd = pend ? l_rd : 0`.
  - `forward_data = pend ? wb_data : 0`.
  - Both are valid regardless of `stall`.
- **Counter wrap:** `wb_count` wraps from 255 to 0.

## Timing
- **Reset values:**
  - `rs1_data` = `rs2_data` = 0 for every address.
  - `ex_wb_rd` = 0, `forward_data` = 0, `wb_count` = 0.
  - All eight registers = 0.
  - Reset must be held for one clock edge.
- **Latency:**
  - An EX result presented in cycle N appears on `ex_wb_rd`/`forward_data` in cycle N+1.
  - It commits at the edge ending cycle N+1.
  - It is readable from the register file from cycle N+2; via bypass it is readable in cycle N+1.
- **Reset mid-operation:** a pending write is not committed on the reset edge.
- **Back-to-back writes to the same rd:** each commits in order; the last one wins.
- **Stall held K cycles:** the latch is frozen, no commit occurs, and `wb_count` is unchanged. The single commit happens on the first edge with `stall` = 0.
- **`flush` and `stall` together:** the latch becomes a bubble, but no commit occurs on that edge.

## Test plan
- **Reset:** after reset, read all 8 addresses → 0; `wb_count` = 0; `ex_wb_rd` = 0.
- **Basic write and forward:** present rd=3, sum=0x25, sel=0, wen=1.
  - Next cycle: `ex_wb_rd` = 3, `forward_data` = 0x25, `rs1_addr`=3 → 0x25 (bypass).
  - Cycle after: `regs[3]` = 0x25, `wb_count` = 1.
- **Immediate select and x0:** rd=5, ext=0xFD, sel=1 → `regs[5]` = 0xFD. Then rd=0, sum=0x77 → `ex_wb_rd` = 0, `forward_data` = 0, read x0 = 0, `wb_count` unchanged.
- **Stall then flush:**
  - Latch rd=2/0x11, stall 3 cycles → `regs[2]` still 0 and count unchanged; release → `regs[2]` = 0x11, count +1.
  - Then latch rd=4/0x99 with `flush` asserted on the load edge → no write to r4, `ex_wb_rd` = 0.
- **Counter wrap:** 256 consecutive commits to r1 → `wb_count` returns to 0 and `regs[1]` holds the last value.
- **Reset mid-flight:** latch rd=6/0x42, assert `reset` on the next edge → `regs[6]` = 0 and all outputs at their reset values.

Source files
------------

// File: rtl/ex_wb_stage.sv
// ex_wb_stage
// EX/WB pipeline latch, write-back mux and 8 x 8-bit register file for the
// 8-bit pipelined core.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   stall               : freeze the latch and suppress the commit this cycle
//   flush               : load a bubble into the latch (wins over stall)
//   signaltoReg_in      : write-back source, 0 = sum_in, 1 = extensor_in
//   writeReg_in         : instruction writes a register
//   rd_in               : destination register
//   sum_in, extensor_in : EX-stage results
//   rs1_addr, rs2_addr  : ID-stage read addresses
//   rs1_data, rs2_data  : combinational read data (with write-through bypass)
//   ex_wb_rd            : destination of the pending write, 0 if none
//   forward_data        : value of the pending write, 0 if none
//   wb_count            : committed register writes, modulo 256
module ex_wb_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       signaltoReg_in,
  input  logic       writeReg_in,
  input  logic [2:0] rd_in,
  input  logic [7:0] sum_in,
  input  logic [7:0] extensor_in,
  input  logic [2:0] rs1_addr,
  input  logic [2:0] rs2_addr,
  output logic [7:0] rs1_data,
  output logic [7:0] rs2_data,
  output logic [2:0] ex_wb_rd,
  output logic [7:0] forward_data,
  output logic [7:0] wb_count
);

  // EX/WB latch
  logic       l_wen_reg, l_wen_next;
  logic       l_sel_reg, l_sel_next;
  logic [2:0] l_rd_reg,  l_rd_next;
  logic [7:0] l_sum_reg, l_sum_next;
  logic [7:0] l_ext_reg, l_ext_next;

  logic [7:0] wb_count_reg;
  logic [7:0] regs_reg [8];

  logic [7:0] wb_data;
  logic       pend;
  logic       commit;

  assign wb_data = l_sel_reg ? l_ext_reg : l_sum_reg;
  // A write to x0 is never pending, which also keeps it out of the count.
  assign pend    = l_wen_reg && (l_rd_reg != 3'd0);
  assign commit  = pend && !stall;

  always_comb begin
    l_wen_next = l_wen_reg;
    l_sel_next = l_sel_reg;
    l_rd_next  = l_rd_reg;
    l_sum_next = l_sum_reg;
    l_ext_next = l_ext_reg;
    if (flush) begin
      l_wen_next = 1'b0;
      l_sel_next = 1'b0;
      l_rd_next  = 3'd0;
      l_sum_next = 8'd0;
      l_ext_next = 8'd0;
    end else if (!stall) begin
      l_wen_next = writeReg_in;
      l_sel_next = signaltoReg_in;
      l_rd_next  = rd_in;
      l_sum_next = sum_in;
      l_ext_next = extensor_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_wen_reg <= 1'b0;
      l_sel_reg <= 1'b0;
      l_rd_reg  <= 3'd0;
      l_sum_reg <= 8'd0;
      l_ext_reg <= 8'd0;
    end else begin
      l_wen_reg <= l_wen_next;
      l_sel_reg <= l_sel_next;
      l_rd_reg  <= l_rd_next;
      l_sum_reg <= l_sum_next;
      l_ext_reg <= l_ext_next;
    end
  end

  // The commit uses the pre-edge latch, so a flush on the same edge only
  // affects what gets loaded, not the write that is leaving.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_reg[i] <= 8'd0;
      end
      wb_count_reg <= 8'd0;
    end else if (commit) begin
      regs_reg[l_rd_reg] <= wb_data;
      wb_count_reg       <= wb_count_reg + 8'd1;
    end
  end

  // Two identical read ports.
  logic [2:0] rd_addr [2];
  logic [7:0] rd_data [2];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read_port
      assign rd_data[gi] = (rd_addr[gi] == 3'd0)                ? 8'd0    :
                           (commit && (rd_addr[gi] == l_rd_reg)) ? wb_data :
                                                                   regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs1_data     = rd_data[0];
  assign rs2_data     = rd_data[1];
  assign ex_wb_rd     = pend ? l_rd_reg : 3'd0;
  assign forward_data = pend ? wb_data  : 8'd0;
  assign wb_count     = wb_count_reg;

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

  logic       clk = 1'b0;
  logic       reset, stall, flush, signaltoReg_in, writeReg_in;
  logic [2:0] rd_in, rs1_addr, rs2_addr, ex_wb_rd;
  logic [7:0] sum_in, extensor_in, rs1_data, rs2_data, forward_data, wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  ex_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .signaltoReg_in(signaltoReg_in), .writeReg_in(writeReg_in),
    .rd_in(rd_in), .sum_in(sum_in), .extensor_in(extensor_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_wb_rd(ex_wb_rd), .forward_data(forward_data), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in write-back and the
  // architectural register file as the program would see it.
  logic       m_wen, m_sel;
  logic [2:0] m_rd;
  logic [7:0] m_sum, m_ext;
  logic [7:0] m_regs [8];
  logic [7:0] m_count;

  function automatic logic [7:0] m_value();
    return m_sel ? m_ext : m_sum;
  endfunction

  function automatic logic m_pending();
    return m_wen && (m_rd != 0);
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a == 0) return 8'd0;
    if (m_pending() && !stall && a == m_rd) return m_value();
    return m_regs[a];
  endfunction

  task automatic model_clear_latch();
    m_wen = 0; m_sel = 0; m_rd = 0; m_sum = 0; m_ext = 0;
  endtask

  // One rising edge: advance the model with the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_clear_latch();
      for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
      m_count = 8'd0;
    end else begin
      if (!stall && m_pending()) begin
        m_regs[m_rd] = m_value();
        m_count      = m_count + 8'd1;
      end
      if (flush) model_clear_latch();
      else if (!stall) begin
        m_wen = writeReg_in; m_sel = signaltoReg_in; m_rd = rd_in;
        m_sum = sum_in;      m_ext = extensor_in;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; signaltoReg_in = 0; writeReg_in = 0;
    rd_in = 0; sum_in = 0; extensor_in = 0;
  endtask

  task automatic present(input logic [2:0] rd, input logic sel,
                         input logic [7:0] sum, input logic [7:0] ext);
    writeReg_in = 1; rd_in = rd; signaltoReg_in = sel; sum_in = sum; extensor_in = ext;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs1_addr = 0; rs2_addr = 0;
    model_clear_latch();
    reset = 1;
    tick();
    reset = 0;
    for (int a = 0; a < 8; a++) begin
      rs1_addr = a[2:0]; rs2_addr = 3'(7 - a);
      #1;
      n_checks++;
      if (rs1_data !== 8'd0) begin n_fail++; $display("FAIL reset_rs1 addr=%0d got=%h exp=00", a, rs1_data); end
      n_checks++;
      if (rs2_data !== 8'd0) begin n_fail++; $display("FAIL reset_rs2 addr=%0d got=%h exp=00", 7 - a, rs2_data); end
    end
    n_checks++;
    if (wb_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
    n_checks++;
    if (ex_wb_rd !== 3'd0 || forward_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_fwd rd=%0d data=%h exp=0/00", ex_wb_rd, forward_data);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    present(3, 0, 8'h25, 8'hC3);
    tick();
    idle_inputs();
    rs1_addr = 3;
    #1;
    n_checks++;
    if (ex_wb_rd !== 3'd3 || forward_data !== 8'h25) begin
      n_fail++; $display("FAIL basic_fwd rd=%0d data=%h exp=3/25", ex_wb_rd, forward_data);
    end
    n_checks++;
    if (rs1_data !== 8'h25) begin n_fail++; $display("FAIL basic_bypass got=%h exp=25", rs1_data); end
    n_checks++;
    if (wb_count !== 8'd0) begin n_fail++; $display("FAIL basic_count_pre got=%0d exp=0", wb_count); end
    tick();
    n_checks++;
    if (rs1_data !== 8'h25 || wb_count !== 8'd1) begin
      n_fail++; $display("FAIL basic_commit r3=%h count=%0d exp=25/1", rs1_data, wb_count);
    end
    $display("test_basic done");
  endtask

  task automatic test_imm_x0();
    present(5, 1, 8'h10, 8'hFD);
    tick();
    idle_inputs();
    tick();
    rs2_addr = 5;
    #1;
    n_checks++;
    if (rs2_data !== 8'hFD || wb_count !== 8'd2) begin
      n_fail++; $display("FAIL imm_commit r5=%h count=%0d exp=FD/2", rs2_data, wb_count);
    end
    present(0, 0, 8'h77, 8'h00);
    tick();
    idle_inputs();
    rs1_addr = 0;
    #1;
    n_checks++;
    if (ex_wb_rd !== 3'd0 || forward_data !== 8'd0 || rs1_data !== 8'd0) begin
      n_fail++; $display("FAIL x0_pending rd=%0d data=%h x0=%h exp=0/00/00", ex_wb_rd, forward_data, rs1_data);
    end
    tick();
    n_checks++;
    if (wb_count !== 8'd2 || rs1_data !== 8'd0) begin
      n_fail++; $display("FAIL x0_commit count=%0d x0=%h exp=2/00", wb_count, rs1_data);
    end
    $display("test_imm_x0 done");
  endtask

  task automatic test_stall_flush();
    present(2, 0, 8'h11, 8'h00);
    tick();
    idle_inputs();
    stall = 1;
    rs1_addr = 2;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (rs1_data !== 8'd0 || wb_count !== 8'd2 || ex_wb_rd !== 3'd2 || forward_data !== 8'h11) begin
        n_fail++; $display("FAIL stall_hold k=%0d r2=%h count=%0d rd=%0d data=%h exp=00/2/2/11",
                           k, rs1_data, wb_count, ex_wb_rd, forward_data);
      end
    end
    stall = 0;
    tick();
    n_checks++;
    if (rs1_data !== 8'h11 || wb_count !== 8'd3) begin
      n_fail++; $display("FAIL stall_release r2=%h count=%0d exp=11/3", rs1_data, wb_count);
    end
    // flush on the load edge turns the instruction into a bubble
    present(4, 0, 8'h99, 8'h00);
    flush = 1;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (ex_wb_rd !== 3'd0 || forward_data !== 8'd0) begin
      n_fail++; $display("FAIL flush_bubble rd=%0d data=%h exp=0/00", ex_wb_rd, forward_data);
    end
    tick();
    rs1_addr = 4;
    #1;
    n_checks++;
    if (rs1_data !== 8'd0 || wb_count !== 8'd3) begin
      n_fail++; $display("FAIL flush_nowrite r4=%h count=%0d exp=00/3", rs1_data, wb_count);
    end
    // flush does not cancel the write leaving on the same edge
    present(7, 0, 8'h3C, 8'h00);
    tick();
    present(4, 0, 8'h99, 8'h00);
    flush = 1;
    tick();
    idle_inputs();
    rs1_addr = 7; rs2_addr = 4;
    #1;
    n_checks++;
    if (rs1_data !== 8'h3C || rs2_data !== 8'd0 || wb_count !== 8'd4 || ex_wb_rd !== 3'd0) begin
      n_fail++; $display("FAIL flush_keeps_commit r7=%h r4=%h count=%0d rd=%0d exp=3C/00/4/0",
                         rs1_data, rs2_data, wb_count, ex_wb_rd);
    end
    // flush together with stall: bubble and no commit
    present(6, 0, 8'h5A, 8'h00);
    tick();
    idle_inputs();
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    #1;
    n_checks++;
    if (ex_wb_rd !== 3'd0 || wb_count !== 8'd4) begin
      n_fail++; $display("FAIL flush_stall rd=%0d count=%0d exp=0/4", ex_wb_rd, wb_count);
    end
    tick();
    rs1_addr = 6;
    #1;
    n_checks++;
    if (rs1_data !== 8'd0 || wb_count !== 8'd4) begin
      n_fail++; $display("FAIL flush_stall_nowrite r6=%h count=%0d exp=00/4", rs1_data, wb_count);
    end
    $display("test_stall_flush done");
  endtask

  task automatic test_wrap();
    logic [7:0] last;
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    last = 0;
    rs1_addr = 1;
    for (int i = 0; i < 256; i++) begin
      last = 8'($urandom);
      present(1, 0, last, 8'($urandom));
      tick();
      if (i % 64 == 5) begin
        n_checks++;
        if (forward_data !== last || rs1_data !== last) begin
          n_fail++; $display("FAIL wrap_fwd i=%0d data=%h r1=%h exp=%h", i, forward_data, rs1_data, last);
        end
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (wb_count !== 8'd0 || rs1_data !== last) begin
      n_fail++; $display("FAIL wrap_count count=%0d r1=%h exp=0/%h", wb_count, rs1_data, last);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_midflight();
    present(6, 0, 8'h42, 8'h00);
    tick();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    rs1_addr = 6; rs2_addr = 1;
    #1;
    n_checks++;
    if (rs1_data !== 8'd0 || rs2_data !== 8'd0 || wb_count !== 8'd0 ||
        ex_wb_rd !== 3'd0 || forward_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_midflight r6=%h r1=%h count=%0d rd=%0d data=%h exp=all zero",
                         rs1_data, rs2_data, wb_count, ex_wb_rd, forward_data);
    end
    $display("test_reset_midflight done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(0, 99) < 2);
      stall          = ($urandom_range(0, 99) < 25);
      flush          = ($urandom_range(0, 99) < 12);
      writeReg_in    = ($urandom_range(0, 99) < 80);
      signaltoReg_in = 1'($urandom);
      rd_in          = 3'($urandom);
      sum_in         = 8'($urandom);
      extensor_in    = 8'($urandom);
      rs1_addr       = 3'($urandom);
      rs2_addr       = 3'($urandom);
      #1;
      n_checks++;
      if (rs1_data !== m_read(rs1_addr) || rs2_data !== m_read(rs2_addr)) begin
        n_fail++; $display("FAIL rand_read c=%0d a1=%0d got=%h exp=%h a2=%0d got=%h exp=%h",
                           c, rs1_addr, rs1_data, m_read(rs1_addr), rs2_addr, rs2_data, m_read(rs2_addr));
      end
      n_checks++;
      if (ex_wb_rd !== (m_pending() ? m_rd : 3'd0) ||
          forward_data !== (m_pending() ? m_value() : 8'd0) || wb_count !== m_count) begin
        n_fail++; $display("FAIL rand_fwd c=%0d rd=%0d data=%h count=%0d exp=%0d/%h/%0d",
                           c, ex_wb_rd, forward_data, wb_count,
                           m_pending() ? m_rd : 3'd0, m_pending() ? m_value() : 8'd0, m_count);
      end
      tick();
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm_x0();
    test_stall_flush();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
